// File: rtl/cpu8_out_fifo_pkg.sv
// Shared definitions for the CPU8 memory-mapped output port.
// Holds the bus addresses of the port, the status-byte bit layout and a
// helper that assembles the status byte from the FIFO state.
package cpu8_out_fifo_pkg;

  localparam logic [7:0] CPU8_IO_DATA_ADDR = 8'h0F;
  localparam logic [7:0] CPU8_IO_STAT_ADDR = 8'h0E;

  localparam int unsigned STAT_FULL    = 32'd0;
  localparam int unsigned STAT_EMPTY   = 32'd1;
  localparam int unsigned STAT_OVF     = 32'd2;
  localparam int unsigned STAT_CNT_LSB = 32'd4;

  // Status byte: {count[3:0], 1'b0, overflow, empty, full}; bit 3 reads as zero.
  function automatic logic [7:0] stat_byte(input logic [3:0] count,
                                           input logic       ovf,
                                           input logic       empty,
                                           input logic       full);
    logic [7:0] s;
    s                      = 8'h00;
    s[STAT_CNT_LSB +: 4]   = count;
    s[STAT_OVF]            = ovf;
    s[STAT_EMPTY]          = empty;
    s[STAT_FULL]           = full;
    return s;
  endfunction

endpackage

// File: rtl/cpu8_sync_fifo.sv
// Generic DEPTH x 8 synchronous FIFO.
// Ports:
//   clk, reset (async, active-low)
//   push/din   - write request and byte; accepted when not full, or when
//                full but a pop happens in the same cycle
//   pop        - read request; ignored while empty
//   dout       - head byte, forced to 8'h00 while empty (no fall-through)
//   full/empty - occupancy flags
//   count      - number of stored bytes, 0..DEPTH
module cpu8_sync_fifo #(
  parameter int unsigned DEPTH = 32'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic [3:0] count
);

  localparam int unsigned AW      = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;
  localparam logic [3:0]  DEPTH_C = 4'(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [3:0]    count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify requests: a pop frees the slot a same-cycle push may then take.
  always_comb begin
    empty     = (count_r == 4'd0);
    full      = (count_r == DEPTH_C);
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= 4'd0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 4'd1;
        2'b01:   count_r <= count_r - 4'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; cleared on reset so no stale byte can ever be presented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_r <= '{default: 8'h00};
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Head byte, held at zero while nothing is stored.
  always_comb begin
    if (empty) begin
      dout = 8'h00;
    end else begin
      dout = mem_r[rd_ptr_r];
    end
  end

  assign count = count_r;

endmodule

// File: rtl/cpu8_out_fifo.sv
// Memory-mapped output port on the CPU8 bus.
// CPU writes to DATA_ADDR push a byte into a FIFO that drains over a
// valid/ready stream; STAT_ADDR is a side-effect-free status register whose
// write with data_in[2]=1 clears the sticky overflow flag.
// Ports:
//   clk, reset (async, active-low)
//   address, data_in, write - CPU bus (write is a one-cycle strobe)
//   rd_data, rd_hit         - status byte and its address decode
//   wr_hit                  - tells the top to suppress the RAM write
//   out_data, out_valid, out_ready - downstream stream
//   overflow                - sticky: a push was dropped
module cpu8_out_fifo
  import cpu8_out_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 32'd8,
  parameter logic [7:0]  DATA_ADDR = CPU8_IO_DATA_ADDR,
  parameter logic [7:0]  STAT_ADDR = CPU8_IO_STAT_ADDR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic [7:0] data_in,
  input  logic       write,
  output logic [7:0] rd_data,
  output logic       rd_hit,
  output logic       wr_hit,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow
);

  logic       data_hit_s;
  logic       push_s;
  logic       pop_s;
  logic       clr_s;
  logic       drop_s;
  logic       full_s;
  logic       empty_s;
  logic [3:0] count_s;
  logic       overflow_r;

  cpu8_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .din   (data_in),
    .pop   (pop_s),
    .dout  (out_data),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Bus decode, stream handshake and status byte assembly.
  always_comb begin
    rd_hit     = (address == STAT_ADDR);
    data_hit_s = (address == DATA_ADDR);
    wr_hit     = write && (data_hit_s || rd_hit);
    push_s     = write && data_hit_s;
    clr_s      = write && rd_hit && data_in[STAT_OVF];
    out_valid  = !empty_s;
    pop_s      = out_valid && out_ready;
    // A full FIFO only drops when no pop frees a slot in the same cycle.
    drop_s     = push_s && full_s && !pop_s;
    rd_data    = stat_byte(count_s, overflow_r, empty_s, full_s);
  end

  // Sticky overflow flag; set and clear never coincide (different addresses).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (clr_s) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign overflow = overflow_r;

endmodule
